// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery precompute block and its neighbours.
package mont_pkg;

  localparam int MONT_WIDTH = 512;

  typedef enum logic [1:0] {
    IDLE,
    DOUBLE,
    FAIL,
    DONE
  } mont_pre_state_t;

  // Iteration counter width: it must reach 2*w-1 with one spare bit so it never wraps.
  function automatic int mont_cnt_width(input int w);
    return $clog2(2 * w) + 1;
  endfunction

  localparam int MONT_CNT_W = mont_cnt_width(MONT_WIDTH);

endpackage

// File: rtl/mont_precompute_mod_double.sv
// Combinational modular doubling: r = 2*v mod m, assuming v < m.
module mod_double #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] diff;

  assign t     = {v_i, 1'b0};
  assign m_ext = {1'b0, m_i};
  assign diff  = t - m_ext;
  // With v < m, 2v < 2m, so a single subtraction always brings the result below m.
  assign r_o   = (t >= m_ext) ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/mont_precompute.sv
// Bit-serial computation of R mod m and R^2 mod m (R = 2^WIDTH) for an odd modulus.
//  state  | meaning
//  IDLE   | waiting for start; results held
//  DOUBLE | one modular doubling per cycle, 2*WIDTH iterations
//  FAIL   | modulus rejected (even or 1); clear results next edge
//  DONE   | done pulse cycle; a start here is accepted like IDLE
module mont_precompute
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] Rmodm,
  output logic [WIDTH-1:0] Rsquaredmodm
);

  localparam int CW = mont_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_R  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_R2 = CW'(2 * WIDTH - 1);

  mont_pre_state_t state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] v_nxt;

  mod_double #(.WIDTH(WIDTH)) u_dbl (
    .v_i (v_q),
    .m_i (m_q),
    .r_o (v_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      r2_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      r_q     <= r_d;
      r2_q    <= r2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    r_d     = r_q;
    r2_d    = r2_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          m_d    = modulus;
          v_d    = WIDTH'(1);
          cnt_d  = '0;
          busy_d = 1'b1;
          err_d  = 1'b0;
          state_d = (!modulus[0] || modulus == WIDTH'(1)) ? FAIL : DOUBLE;
        end
      end
      DOUBLE: begin
        v_d   = v_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_R) r_d = v_nxt;
        if (cnt_q == LAST_R2) begin
          r2_d    = v_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      FAIL: begin
        r_d     = '0;
        r2_d    = '0;
        done_d  = 1'b1;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign Rmodm        = r_q;
  assign Rsquaredmodm = r2_q;

endmodule

// File: tb/tb_mont_precompute.sv
// Bench for mont_precompute: directed and randomized runs at WIDTH=8, reference vectors at WIDTH=512.
module tb_mont_precompute;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic         s8 = 1'b0;
  logic [7:0]   m8 = '0;
  logic         b8, d8, e8;
  logic [7:0]   r8, q8;

  logic         s5 = 1'b0;
  logic [511:0] m5 = '0;
  logic         b5, d5, e5;
  logic [511:0] r5, q5;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  mont_precompute #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .modulus(m8),
    .busy(b8), .done(d8), .error(e8), .Rmodm(r8), .Rsquaredmodm(q8)
  );

  mont_precompute #(.WIDTH(512)) dut512 (
    .clk(clk), .reset(reset), .start(s5), .modulus(m5),
    .busy(b5), .done(d5), .error(e5), .Rmodm(r5), .Rsquaredmodm(q5)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_bad(input logic [7:0] m);
    return (m[0] == 1'b0) || (m == 8'd1);
  endfunction

  // 2^e mod m by direct arithmetic
  function automatic logic [7:0] ref_pow(input logic [7:0] m, input int e);
    longint unsigned p;
    p = 64'd1 << e;
    return 8'(p % longint'(m));
  endfunction

  // One WIDTH=8 run starting from the current cycle; optional start/modulus poke mid-run.
  task automatic run8(input logic [7:0] m, input int poke_at, input logic [7:0] poke_m);
    int busy_cnt;
    int done_cnt;
    m8 = m;
    s8 = 1'b1;
    tick();
    s8 = 1'b0;
    chk("busy_e0", b8, 1);
    if (ref_bad(m)) begin
      tick();
      chk("fail_done", d8, 1);
      chk("fail_err", e8, 1);
      chk("fail_r", r8, 0);
      chk("fail_r2", q8, 0);
      chk("fail_busy", b8, 0);
    end else begin
      busy_cnt = 1;
      done_cnt = 0;
      for (int k = 1; k <= 16; k++) begin
        if (k == poke_at) begin
          s8 = 1'b1;
          m8 = poke_m;
        end
        tick();
        s8 = 1'b0;
        if (k < 16) begin
          busy_cnt += int'(b8);
          done_cnt += int'(d8);
        end
        if (k == 8) chk("r_at_e8", r8, ref_pow(m, 8));
      end
      chk("early_done", done_cnt, 0);
      chk("busy_cycles", busy_cnt, 16);
      chk("done_e16", d8, 1);
      chk("err_e16", e8, 0);
      chk("busy_e16", b8, 0);
      chk("r_e16", r8, ref_pow(m, 8));
      chk("r2_e16", q8, ref_pow(m, 16));
    end
  endtask

  initial begin
    logic [511:0] m512, r512, q512;
    logic [7:0]   mr;
    int           dc;
    m512 = 512'hdceac5e50da445f7dd934035526358f5d389530f8dd5d8eeadf7fa0ec7111226b065f9def941b048878c64d8c6e3bf40bf03afe8d9a801990261800ebcedefe9;
    r512 = 512'h23153a1af25bba08226cbfcaad9ca70a2c76acf0722a2711520805f138eeedd94f9a062106be4fb778739b27391c40bf40fc50172657fe66fd9e7ff143121017;
    q512 = 512'h20fda8607f75f644b3200c20c9d38d83c3a9231ce730be4ea13b4844c05b90b5f7e0fb03be9bca4311c30d94d7c4274f6ace51b2f3b4f9642d3397e4ea1ba083;

    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", b8, 0);
    chk("rst_done", d8, 0);
    chk("rst_err", e8, 0);
    chk("rst_r", r8, 0);
    chk("rst_r2", q8, 0);
    chk("rst_r512", r5, 0);

    // basic run, then outputs hold in IDLE
    run8(8'd13, 0, 8'd0);
    repeat (4) tick();
    chk("hold_done", d8, 0);
    chk("hold_r", r8, 9);
    chk("hold_r2", q8, 3);

    // rejected moduli; results cleared
    run8(8'd12, 0, 8'd0);
    tick();
    chk("fail_pulse", d8, 0);
    chk("fail_err_hold", e8, 1);
    run8(8'd1, 0, 8'd0);
    tick();

    // start and modulus changes mid-run are ignored
    run8(8'd13, 5, 8'd11);
    dc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      dc += int'(d8) + int'(b8);
    end
    chk("no_restart", dc, 0);

    // back-to-back: start held through the DONE cycle
    run8(8'd13, 0, 8'd0);
    run8(8'd11, 0, 8'd0);
    tick();

    // reset in the middle of a run
    m8 = 8'd13;
    s8 = 1'b1;
    tick();
    s8 = 1'b0;
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", b8, 0);
    chk("mid_rst_done", d8, 0);
    chk("mid_rst_r", r8, 0);
    chk("mid_rst_r2", q8, 0);
    repeat (3) tick();
    reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      dc += int'(d8) + int'(b8);
    end
    chk("post_rst_idle", dc, 0);
    run8(8'd13, 0, 8'd0);
    tick();

    // randomized moduli against the arithmetic model
    for (int n = 0; n < 24; n++) begin
      mr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) mr[0] = 1'b1;
      run8(mr, 0, 8'd0);
      repeat (2) tick();
      chk("rnd_err_hold", e8, ref_bad(mr));
      chk("rnd_r_hold", r8, ref_bad(mr) ? 8'd0 : ref_pow(mr, 8));
    end

    // WIDTH=512 reference vector
    m5 = m512;
    s5 = 1'b1;
    tick();
    s5 = 1'b0;
    chk("w512_busy", b5, 1);
    repeat (512) tick();
    chk("w512_r_e512", r5, r512);
    repeat (511) tick();
    chk("w512_done_e1023", d5, 0);
    tick();
    chk("w512_done", d5, 1);
    chk("w512_err", e5, 0);
    chk("w512_r", r5, r512);
    chk("w512_r2", q5, q512);

    // WIDTH=512 even modulus
    m5 = m512 ^ 512'd1;
    s5 = 1'b1;
    tick();
    s5 = 1'b0;
    tick();
    chk("w512_even_done", d5, 1);
    chk("w512_even_err", e5, 1);
    chk("w512_even_r", r5, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
